mcpu_ctrl_fsm: RTL

- Multi-cycle successor to the single-cycle SCPU control decoder.
- Decodes RV32I (R, I-ALU, load, store, full branch set, jal, jalr, lui, auipc) into a per-state control sequence for a shared-memory multi-cycle datapath.
- Stalls on MIO_ready, times out on stuck bus transfers, and traps on illegal opcodes.
- Sits between the IR fields and the multi-cycle datapath; memory is reached through the MIO bus.

---
 rtl/mcpu_ctrl_fsm.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mcpu_ctrl_fsm.sv
// mcpu_ctrl_fsm: multi-cycle RV32I control sequencer with bus-wait timeout and illegal-opcode trap
module mcpu_ctrl_fsm #(
  parameter int WAIT_TIMEOUT = 16,
  parameter int TO_W         = 5,
  parameter bit EN_AUIPC     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] OPcode,
  input  logic [2:0] Fun3,
  input  logic       Fun7,
  input  logic       MIO_ready,
  input  logic       br_taken,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [1:0] mem_size,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALU_Control,
  output logic [2:0] ImmSel,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic [1:0] PCSource,
  output logic       inst_done,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);
  localparam logic [3:0] S_IDLE = 4'd0, S_IF = 4'd1, S_ID = 4'd2, S_EXE = 4'd3, S_MADDR = 4'd4,
                         S_MRD = 4'd5, S_MWR = 4'd6, S_WBM = 4'd7, S_WBA = 4'd8, S_BR = 4'd9,
                         S_JAL = 4'd10, S_JALR = 4'd11, S_LUI = 4'd12, S_AUIPC = 4'd13, S_TRAP = 4'd15;
  localparam logic [3:0] ALU_ADD = 4'b0010, ALU_SUB = 4'b0110;
  logic [3:0]      state_q, state_d, id_nxt;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            illegal_q, bus_err_q, wait_st, to, ill_op;
  logic [3:0]      alu_fn;
  assign state   = state_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign wait_st = (state_q == S_IF) || (state_q == S_MRD) || (state_q == S_MWR);
  assign to      = (WAIT_TIMEOUT != 0) && wait_st && !MIO_ready && (cnt_q == TO_W'(WAIT_TIMEOUT - 1));
  assign ill_op  = (state_q == S_ID) && (id_nxt == S_TRAP);
  // opcode dispatch out of ID; branch Fun3 010/011 has no encoding and traps
  always_comb begin
    id_nxt = S_TRAP;
    case (OPcode)
      5'b01100, 5'b00100: id_nxt = S_EXE;
      5'b00000, 5'b01000: id_nxt = S_MADDR;
      5'b11000:           id_nxt = (Fun3[2:1] == 2'b01) ? S_TRAP : S_BR;
      5'b11011:           id_nxt = S_JAL;
      5'b11001:           id_nxt = S_JALR;
      5'b01101:           id_nxt = S_LUI;
      5'b00101:           id_nxt = EN_AUIPC ? S_AUIPC : S_TRAP;
      default:            id_nxt = S_TRAP;
    endcase
  end
  // ALU function for R/I arithmetic; I-type only honours Fun7 on shifts-right
  always_comb begin
    alu_fn = ALU_ADD;
    case (Fun3)
      3'b000: alu_fn = (OPcode[3] && Fun7) ? ALU_SUB : ALU_ADD;
      3'b001: alu_fn = 4'b1110;
      3'b010: alu_fn = 4'b0111;
      3'b011: alu_fn = 4'b1001;
      3'b100: alu_fn = 4'b1100;
      3'b101: alu_fn = Fun7 ? 4'b1111 : 4'b1101;
      3'b110: alu_fn = 4'b0001;
      default: alu_fn = 4'b0000;
    endcase
  end
  // next-state and wait counter; a ready on the final wait cycle beats the timeout
  always_comb begin
    state_d = S_TRAP;
    case (state_q)
      S_IDLE:  state_d = S_IF;
      S_IF:    state_d = to ? S_TRAP : (MIO_ready ? S_ID : S_IF);
      S_ID:    state_d = id_nxt;
      S_EXE:   state_d = S_WBA;
      S_MADDR: state_d = OPcode[3] ? S_MWR : S_MRD;
      S_MRD:   state_d = to ? S_TRAP : (MIO_ready ? S_WBM : S_MRD);
      S_MWR:   state_d = to ? S_TRAP : (MIO_ready ? S_IF : S_MWR);
      S_AUIPC: state_d = S_WBA;
      S_WBA, S_WBM, S_BR, S_JAL, S_JALR, S_LUI: state_d = S_IF;
      default: state_d = S_TRAP;
    endcase
    cnt_d = (wait_st && !MIO_ready && state_d == state_q) ? cnt_q + 1'b1 : '0;
  end
  // state, counter and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_q | ill_op;
      bus_err_q <= bus_err_q | to;
    end
  end
  // per-state datapath controls
  always_comb begin
    PCWrite = 1'b0; IRWrite = 1'b0; IorD = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    mem_size = 2'b00; ALUSrcA = 2'd0; ALUSrcB = 2'd0; ALU_Control = 4'b0000; ImmSel = 3'd0;
    MemtoReg = 2'd0; RegWrite = 1'b0; PCSource = 2'd0; inst_done = 1'b0;
    case (state_q)
      S_IF: begin
        MemRead = 1'b1; ALUSrcB = 2'd2; ALU_Control = ALU_ADD; mem_size = 2'b10;
        IRWrite = MIO_ready; PCWrite = MIO_ready;
      end
      S_ID: begin
        ALUSrcA = 2'd2; ALUSrcB = 2'd1; ALU_Control = ALU_ADD;
        ImmSel = (OPcode == 5'b11011) ? 3'd3 : 3'd2;
      end
      S_EXE: begin
        ALUSrcA = 2'd1; ALUSrcB = OPcode[3] ? 2'd0 : 2'd1; ALU_Control = alu_fn;
      end
      S_WBA: begin
        RegWrite = 1'b1; inst_done = 1'b1;
      end
      S_MADDR: begin
        ALUSrcA = 2'd1; ALUSrcB = 2'd1; ALU_Control = ALU_ADD; mem_size = Fun3[1:0];
        ImmSel = OPcode[3] ? 3'd1 : 3'd0;
      end
      S_MRD: begin
        IorD = 1'b1; MemRead = 1'b1; mem_size = Fun3[1:0];
      end
      S_WBM: begin
        RegWrite = 1'b1; MemtoReg = 2'd1; inst_done = 1'b1;
      end
      S_MWR: begin
        IorD = 1'b1; MemWrite = 1'b1; mem_size = Fun3[1:0]; inst_done = MIO_ready;
      end
      S_BR: begin
        ALUSrcA = 2'd1; ALU_Control = ALU_SUB; PCWrite = br_taken; PCSource = 2'd1; inst_done = 1'b1;
      end
      S_JAL: begin
        PCWrite = 1'b1; PCSource = 2'd1; RegWrite = 1'b1; MemtoReg = 2'd2; inst_done = 1'b1;
      end
      S_JALR: begin
        ALUSrcA = 2'd1; ALUSrcB = 2'd1; ALU_Control = ALU_ADD; PCSource = 2'd2;
        PCWrite = 1'b1; RegWrite = 1'b1; MemtoReg = 2'd2; inst_done = 1'b1;
      end
      S_LUI: begin
        ImmSel = 3'd4; MemtoReg = 2'd3; RegWrite = 1'b1; inst_done = 1'b1;
      end
      S_AUIPC: begin
        ALUSrcA = 2'd2; ALUSrcB = 2'd1; ImmSel = 3'd4; ALU_Control = ALU_ADD;
      end
      default: ;
    endcase
  end
endmodule
